picoctrl_prog_loader: RTL and testbench
=======================================

Name: picoctrl_prog_loader

Overview:
- Owns the PicoCTRL instruction memory. Sequences the core's reset around program download.
- A host streams 16-bit instruction words over a valid/ready interface. The block writes them from address 0, pads the unused tail with NOP, then releases the core's reset.
- While the core runs, the block serves its instruction fetches combinationally from the stored program.

Parameters:
- ADDR_W, 5, instruction address width; memory depth DEPTH = 2**ADDR_W.
- DATA_W, 16, instruction word width.
- NOP_WORD, 16'h8000, padding word and fetch data returned when the core is not running.
- RST_HOLD, 2, clk cycles core_res_n stays low in RELEASE (minimum 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- res_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to begin a download.
- ld_valid  in  1  host word valid.
- ld_data  in  DATA_W  host instruction word.
- ld_last  in  1  qualifies the final word of a download.
- ld_ready  out  1  block accepts a word this cycle.
- core_res_n  out  1  registered active-low reset to the PicoCTRL core.
- rom_addr  in  ADDR_W  fetch address from the core.
- rom_data  out  DATA_W  fetch data to the core, combinational.
- running  out  1  high in RUN.
- loaded_count  out  ADDR_W+1  host words accepted in the most recent download (0..DEPTH).
- err_trunc  out  1  sticky flag: DEPTH words accepted without ld_last.

Behaviour:
- Clock and reset: one clock, clk. Reset res_n is asynchronous and active-low.
- Values on reset:
  - State is IDLE.
  - core_res_n=0, ld_ready=0, running=0, loaded_count=0, err_trunc=0.
  - Internal write pointer wr_ptr=0, hold counter=0.
- Memory:
  - Memory is not reset; contents are undefined until the first download completes.
  - The core stays in reset until then.
- States:
  - IDLE: core_res_n=0. If load_start=1, go to LOAD next cycle with wr_ptr=0, loaded_count=0 and err_trunc cleared.
  - LOAD:
    - ld_ready = 1 (combinational on state).
    - A transfer occurs when ld_valid & ld_ready. It writes mem[wr_ptr]=ld_data, then wr_ptr+1 and loaded_count+1.
    - Transfer with ld_last at wr_ptr<DEPTH-1: go to FILL with wr_ptr+1.
    - Transfer at wr_ptr=DEPTH-1: go to RELEASE. Set err_trunc=1 if ld_last=0.
    - ld_last without ld_valid is ignored.
  - FILL:
    - Writes NOP_WORD to mem[wr_ptr] each cycle and increments wr_ptr.
    - After writing DEPTH-1, go to RELEASE.
    - A 1-word download takes DEPTH-1 FILL cycles.
  - RELEASE: core_res_n=0 for RST_HOLD cycles (hold counter), then RUN.
  - RUN:
    - core_res_n=1 is registered, so the first RUN cycle shows 1.
    - running=1, rom_data=mem[rom_addr] (asynchronous read, zero latency).
    - load_start=1 goes to LOAD next cycle. core_res_n=0 from that same edge, wr_ptr=0, loaded_count=0, err_trunc=0.
- rom_data in any state other than RUN is NOP_WORD.
- load_start is ignored in LOAD, FILL and RELEASE.
- ld_ready=0 outside LOAD. Words offered then are not consumed. After a truncated download, extra host words remain unaccepted.
- loaded_count and err_trunc hold their values through RUN until the next download starts.
- Wrap-around: wr_ptr never wraps. The transition out of LOAD/FILL occurs on the write to DEPTH-1.
- Reset asserted mid-operation (any state) returns to IDLE asynchronously. The core is held in reset and the partially written memory is treated as invalid.

Test Plan:
- Reset, then load_start and 3 words {16'h5103, 16'h0002, 16'h8000} with ld_last on the third -> ld_ready high 3 transfer cycles, 29 FILL cycles, 2 RELEASE cycles. Then core_res_n=1, running=1, loaded_count=3. rom_addr=0 gives 16'h5103 and rom_addr=17 gives 16'h8000.
- Download 32 words with ld_last on word 32 -> no FILL cycles, err_trunc=0, loaded_count=32. Every address reads back its written word.
- Download 32 words with ld_last never asserted, host keeps ld_valid high -> word 33 not accepted (ld_ready=0), err_trunc=1, loaded_count=32, RUN entered.
- ld_valid toggled 1/0 each cycle during a 4-word load -> exactly 4 writes at addresses 0..3. Stall cycles neither write nor advance wr_ptr.
- From RUN with program A, pulse load_start -> core_res_n=0 on the next edge and rom_data=16'h8000. A new 2-word program B then reads back, and addresses 2..31 hold 16'h8000 (no residue from A).
- Assert res_n=0 mid-FILL -> immediately core_res_n=0, running=0, ld_ready=0, state IDLE. Release res_n -> block stays in IDLE until load_start.

Source files
------------

// File: rtl/picoctrl_prog_loader.sv
// PicoCTRL program loader: accepts a host-streamed program into instruction
// memory, pads the tail with NOP, sequences the core reset and serves fetches.
module picoctrl_prog_loader #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h8000,
  parameter int                RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              core_res_n,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              running,
  output logic [ADDR_W:0]   loaded_count,
  output logic              err_trunc
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_core_res_n;
  logic [ADDR_W:0]     r_loaded_count;
  logic                r_err_trunc;

  // Instruction memory has no reset; its contents only matter once RUN is reached.
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_xfer;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_at_end;

  assign w_xfer      = (r_state == S_LOAD) && ld_valid;
  assign w_mem_we    = w_xfer || (r_state == S_FILL);
  assign w_mem_wdata = (r_state == S_LOAD) ? ld_data : NOP_WORD;
  assign w_at_end    = (r_wr_ptr == ADDR_W'(DEPTH - 1));

  // Host words while loading, NOP padding while filling.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= w_mem_wdata;
    end
  end

  // Download / reset-release sequencer.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_hold         <= '0;
      r_core_res_n   <= 1'b0;
      r_loaded_count <= '0;
      r_err_trunc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            r_state        <= S_LOAD;
            r_wr_ptr       <= '0;
            r_loaded_count <= '0;
            r_err_trunc    <= 1'b0;
            r_core_res_n   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_loaded_count <= r_loaded_count + (ADDR_W+1)'(1);
            if (w_at_end) begin
              // Memory is full: the program ends here whether or not it said so.
              r_state     <= S_RELEASE;
              r_hold      <= '0;
              r_err_trunc <= ~ld_last;
            end else begin
              r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
              if (ld_last) begin
                r_state <= S_FILL;
              end
            end
          end
        end
        S_FILL: begin
          if (w_at_end) begin
            r_state <= S_RELEASE;
            r_hold  <= '0;
          end else begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
          end
        end
        S_RELEASE: begin
          if (r_hold == HOLD_W'(RST_HOLD - 1)) begin
            r_state      <= S_RUN;
            r_core_res_n <= 1'b1;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_core_res_n <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready     = (r_state == S_LOAD);
  assign running      = (r_state == S_RUN);
  assign core_res_n   = r_core_res_n;
  assign loaded_count = r_loaded_count;
  assign err_trunc    = r_err_trunc;
  assign rom_data     = running ? r_mem[rom_addr] : NOP_WORD;

endmodule

// File: tb/tb_picoctrl_prog_loader.sv
// Bench for picoctrl_prog_loader: directed downloads checked against a
// phase/countdown model every cycle, plus hand-computed literal checks.
module tb_picoctrl_prog_loader;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int DEPTH    = 32;
  localparam int RST_HOLD = 2;
  localparam logic [15:0] NOP = 16'h8000;

  logic              clk = 1'b0;
  logic              res_n = 1'b0;
  logic              load_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              core_res_n;
  logic [ADDR_W-1:0] rom_addr = '0;
  logic [DATA_W-1:0] rom_data;
  logic              running;
  logic [ADDR_W:0]   loaded_count;
  logic              err_trunc;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  picoctrl_prog_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .res_n(res_n), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .core_res_n(core_res_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .running(running), .loaded_count(loaded_count), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: 0 idle, 1 accepting words, 2 busy (padding + reset hold), 3 running.
  int          m_mode;
  int          m_cnt;
  logic        m_err;
  int          m_busy_left;
  logic [15:0] m_mem [DEPTH];

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_mode <= 0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
      m_busy_left <= 0;
    end else begin
      case (m_mode)
        0, 3: begin
          if (load_start) begin
            m_mode <= 1;
            m_cnt  <= 0;
            m_err  <= 1'b0;
          end
        end
        1: begin
          if (ld_valid) begin
            m_mem[m_cnt] <= ld_data;
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == DEPTH) begin
              m_err <= ~ld_last;
              m_mode <= 2;
              m_busy_left <= RST_HOLD;
            end else if (ld_last) begin
              m_mode <= 2;
              m_busy_left <= (DEPTH - (m_cnt + 1)) + RST_HOLD;
              for (int k = 0; k < DEPTH; k++)
                if (k > m_cnt) m_mem[k] <= NOP;
            end
          end
        end
        default: begin
          if (m_busy_left == 1) m_mode <= 3;
          else m_busy_left <= m_busy_left - 1;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_ld_ready", 32'(ld_ready), 32'(m_mode == 1));
      chk("cyc_core_res_n", 32'(core_res_n), 32'(m_mode == 3));
      chk("cyc_running", 32'(running), 32'(m_mode == 3));
      chk("cyc_loaded_count", 32'(loaded_count), 32'(m_cnt));
      chk("cyc_err_trunc", 32'(err_trunc), 32'(m_err));
      chk("cyc_rom_data", 32'(rom_data), 32'((m_mode == 3) ? m_mem[rom_addr] : NOP));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int t = 0;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    @(negedge clk);
    while (!ld_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!ld_ready) chk("send_accept", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_run(output int busy);
    busy = 0;
    @(negedge clk);
    while (!running && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    if (!running) chk("run_timeout", 32'(running), 32'd1);
    step();
  endtask

  task automatic read_chk(input string name, input logic [4:0] a, input logic [15:0] exp);
    rom_addr = a;
    @(negedge clk);
    $display("read %s addr=%0d data=%h", name, a, rom_data);
    chk(name, 32'(rom_data), 32'(exp));
    step();
  endtask

  int busy;
  logic [15:0] prog [DEPTH];

  initial begin
    // Reset state
    repeat (2) step();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_core_res_n", 32'(core_res_n), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_loaded_count", 32'(loaded_count), 32'd0);
    chk("rst_err_trunc", 32'(err_trunc), 32'd0);
    step();
    res_n = 1'b1;
    step();

    // Three-word program
    pulse_start();
    send(16'h5103, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h8000, 1'b1);
    wait_run(busy);
    $display("t1 3-word load busy=%0d count=%0d", busy, loaded_count);
    chk("t1_busy_cycles", 32'(busy), 32'd31);
    chk("t1_loaded_count", 32'(loaded_count), 32'd3);
    chk("t1_core_res_n", 32'(core_res_n), 32'd1);
    read_chk("t1_addr0", 5'd0, 16'h5103);
    read_chk("t1_addr17", 5'd17, 16'h8000);

    // Full 32-word program terminated by ld_last
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'h1000 + 16'(i * 7);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(prog[i], (i == DEPTH - 1));
    wait_run(busy);
    $display("t2 full load busy=%0d count=%0d err=%0d", busy, loaded_count, err_trunc);
    chk("t2_busy_cycles", 32'(busy), 32'd2);
    chk("t2_loaded_count", 32'(loaded_count), 32'd32);
    chk("t2_err_trunc", 32'(err_trunc), 32'd0);
    for (int i = 0; i < DEPTH; i++) read_chk("t2_readback", 5'(i), prog[i]);

    // Truncated download: host never marks last and keeps offering words
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(16'h2000 + 16'(i), 1'b0);
    ld_valid = 1'b1; ld_data = 16'hDEAD;
    @(negedge clk);
    chk("t3_word33_ready", 32'(ld_ready), 32'd0);
    wait_run(busy);
    ld_valid = 1'b0;
    $display("t3 truncated busy=%0d count=%0d err=%0d", busy, loaded_count, err_trunc);
    chk("t3_err_trunc", 32'(err_trunc), 32'd1);
    chk("t3_loaded_count", 32'(loaded_count), 32'd32);
    read_chk("t3_addr31", 5'd31, 16'h201F);

    // Stalled 4-word download: valid toggles every cycle
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data = 16'hA000 + 16'(i);
      ld_last = (i == 6);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    wait_run(busy);
    $display("t4 stalled load busy=%0d count=%0d", busy, loaded_count);
    chk("t4_busy_cycles", 32'(busy), 32'd30);
    chk("t4_loaded_count", 32'(loaded_count), 32'd4);
    read_chk("t4_addr0", 5'd0, 16'hA000);
    read_chk("t4_addr1", 5'd1, 16'hA002);
    read_chk("t4_addr2", 5'd2, 16'hA004);
    read_chk("t4_addr3", 5'd3, 16'hA006);
    read_chk("t4_addr4", 5'd4, 16'h8000);

    // Reload from RUN with a 2-word program B
    rom_addr = 5'd1;
    pulse_start();
    $display("t5 reload core_res_n=%0d rom_data=%h", core_res_n, rom_data);
    chk("t5_core_res_n", 32'(core_res_n), 32'd0);
    chk("t5_rom_nop", 32'(rom_data), 32'h8000);
    send(16'h1234, 1'b0);
    send(16'h4321, 1'b1);
    wait_run(busy);
    chk("t5_busy_cycles", 32'(busy), 32'd32);
    read_chk("t5_addr0", 5'd0, 16'h1234);
    read_chk("t5_addr1", 5'd1, 16'h4321);
    for (int i = 2; i < DEPTH; i++) read_chk("t5_pad", 5'(i), 16'h8000);

    // Asynchronous reset during FILL
    pulse_start();
    send(16'h7777, 1'b1);
    repeat (5) step();
    #2 res_n = 1'b0;
    #1;
    $display("t6 async reset core_res_n=%0d running=%0d ld_ready=%0d", core_res_n, running, ld_ready);
    chk("t6_core_res_n", 32'(core_res_n), 32'd0);
    chk("t6_running", 32'(running), 32'd0);
    chk("t6_ld_ready", 32'(ld_ready), 32'd0);
    step();
    res_n = 1'b1;
    repeat (4) step();
    chk("t6_idle_ready", 32'(ld_ready), 32'd0);
    pulse_start();
    @(negedge clk);
    chk("t6_restart_ready", 32'(ld_ready), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
